// File: rtl/fir_rx_pkg.sv
// Shared types and helpers for the FIR receive-side sample assembler.
package fir_rx_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    COLLECT  = 2'b00,
    DISPATCH = 2'b01,
    WAIT_OUT = 2'b10
  } state_t;

  // Index width for a counter/selector over n positions, never narrower than 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_rx_sample_assembler_packer.sv
// Slot-addressed word register: places each received word into its sample slot.
module rx_byte_packer
  import fir_rx_pkg::*;
#(
  parameter int unsigned BYTE_W           = 8,
  parameter int unsigned BYTES_PER_SAMPLE = 2,
  parameter int unsigned MSB_FIRST        = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_wr_en,
  input  logic [idx_width(BYTES_PER_SAMPLE)-1:0] i_slot_idx,
  input  logic [BYTE_W-1:0]                    i_word,
  output logic [BYTE_W*BYTES_PER_SAMPLE-1:0]   o_sample
);

  localparam int unsigned IDX_W = idx_width(BYTES_PER_SAMPLE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_SAMPLE - 1);

  logic [BYTE_W-1:0] r_slot [BYTES_PER_SAMPLE];
  logic [IDX_W-1:0]  w_slot;

  // i_slot_idx is the arrival position; map it to the physical slot by byte order.
  always_comb begin
    w_slot = (MSB_FIRST != 0) ? (LAST_IDX - i_slot_idx) : i_slot_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BYTES_PER_SAMPLE; i++) begin
        r_slot[i] <= '0;
      end
    end else if (i_wr_en) begin
      for (int unsigned i = 0; i < BYTES_PER_SAMPLE; i++) begin
        if (w_slot == IDX_W'(i)) begin
          r_slot[i] <= i_word;
        end
      end
    end
  end

  always_comb begin
    o_sample = '0;
    for (int unsigned i = 0; i < BYTES_PER_SAMPLE; i++) begin
      o_sample[i*BYTE_W +: BYTE_W] = r_slot[i];
    end
  end

endmodule

// File: rtl/fir_rx_sample_assembler.sv
// Receive-side controller: packs words into samples, hands them to the FIR and
// waits for its result; reports inter-word timeouts and words dropped while busy.
module fir_rx_sample_assembler
  import fir_rx_pkg::*;
#(
  parameter int unsigned BYTE_W           = 8,
  parameter int unsigned BYTES_PER_SAMPLE = 2,
  parameter int unsigned MSB_FIRST        = 0,
  parameter int unsigned TIMEOUT_CYC      = 1024,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [BYTE_W-1:0]                      rx_data,
  input  logic                                   rx_ready,
  input  logic                                   fir_out_valid,
  output logic [BYTE_W*BYTES_PER_SAMPLE-1:0]     fir_in_data,
  output logic                                   fir_in_valid,
  output logic                                   busy,
  output logic [idx_width(BYTES_PER_SAMPLE)-1:0] byte_idx,
  output logic                                   overrun,
  output logic                                   frame_err,
  output logic [CNT_W-1:0]                       sample_cnt
);

  localparam int unsigned IDX_W = idx_width(BYTES_PER_SAMPLE);
  localparam int unsigned TMO_W = idx_width(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_SAMPLE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT_CYC > 0) && (BYTES_PER_SAMPLE > 1);

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_byte_idx;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [CNT_W-1:0]  r_sample_cnt;
  logic              r_overrun;
  logic              r_frame_err;
  logic              w_accept;
  logic              w_last;
  logic              w_timeout;
  logic              w_fir_in_valid;
  logic              w_busy;

  always_comb begin
    w_accept  = (r_state == COLLECT) && rx_ready;
    w_last    = (r_byte_idx == LAST_IDX);
    // A word arriving on the expiry cycle takes priority over the timeout.
    w_timeout = TMO_EN && (r_state == COLLECT) && (r_byte_idx != '0) &&
                !rx_ready && (r_tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      COLLECT:  if (w_accept && w_last) w_next = DISPATCH;
      DISPATCH: w_next = WAIT_OUT;
      WAIT_OUT: if (fir_out_valid) w_next = COLLECT;
      default:  w_next = COLLECT;
    endcase
  end

  always_comb begin
    w_fir_in_valid = 1'b0;
    w_busy         = 1'b0;
    case (r_state)
      DISPATCH: begin
        w_fir_in_valid = 1'b1;
        w_busy         = 1'b1;
      end
      WAIT_OUT: w_busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_idx   <= '0;
      r_tmo_cnt    <= '0;
      r_sample_cnt <= '0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_overrun   <= rx_ready && (r_state != COLLECT);
      r_frame_err <= w_timeout;

      if (r_state == DISPATCH) begin
        r_sample_cnt <= r_sample_cnt + 1'b1;
      end

      if (w_accept) begin
        r_byte_idx <= w_last ? '0 : r_byte_idx + 1'b1;
      end else if (w_timeout) begin
        r_byte_idx <= '0;
      end

      if (!TMO_EN || w_accept || w_timeout || (r_state != COLLECT) || (r_byte_idx == '0)) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  rx_byte_packer #(
    .BYTE_W           (BYTE_W),
    .BYTES_PER_SAMPLE (BYTES_PER_SAMPLE),
    .MSB_FIRST        (MSB_FIRST)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_accept),
    .i_slot_idx (r_byte_idx),
    .i_word     (rx_data),
    .o_sample   (fir_in_data)
  );

  assign fir_in_valid = w_fir_in_valid;
  assign busy         = w_busy;
  assign byte_idx     = r_byte_idx;
  assign overrun      = r_overrun;
  assign frame_err    = r_frame_err;
  assign sample_cnt   = r_sample_cnt;

endmodule

// File: tb/tb_fir_rx_sample_assembler.sv
// Directed bench for fir_rx_sample_assembler across three parameter sets.
module tb_fir_rx_sample_assembler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;
  logic       fov = 1'b0;

  logic [15:0] data_a;  logic val_a, busy_a, ovr_a, ferr_a; logic [0:0] idx_a; logic [15:0] cnt_a;
  logic [23:0] data_b;  logic val_b, busy_b, ovr_b, ferr_b; logic [1:0] idx_b; logic [15:0] cnt_b;
  logic [15:0] data_c;  logic val_c, busy_c, ovr_c, ferr_c; logic [0:0] idx_c; logic [1:0]  cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_rx_sample_assembler u_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rdy_a), .fir_out_valid(fov),
    .fir_in_data(data_a), .fir_in_valid(val_a), .busy(busy_a), .byte_idx(idx_a),
    .overrun(ovr_a), .frame_err(ferr_a), .sample_cnt(cnt_a));

  fir_rx_sample_assembler #(.BYTES_PER_SAMPLE(3), .MSB_FIRST(1), .TIMEOUT_CYC(8)) u_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rdy_b), .fir_out_valid(fov),
    .fir_in_data(data_b), .fir_in_valid(val_b), .busy(busy_b), .byte_idx(idx_b),
    .overrun(ovr_b), .frame_err(ferr_b), .sample_cnt(cnt_b));

  fir_rx_sample_assembler #(.CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rdy_c), .fir_out_valid(fov),
    .fir_in_data(data_c), .fir_in_valid(val_c), .busy(busy_c), .byte_idx(idx_c),
    .overrun(ovr_c), .frame_err(ferr_c), .sample_cnt(cnt_c));

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [1:0] exp_cnt;
  } cnt_vec_t;

  vec_t     vecs  [4];
  cnt_vec_t cvecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input int d, input logic [7:0] b);
    rx_data = b;
    case (d)
      0:       rdy_a = 1'b1;
      1:       rdy_b = 1'b1;
      default: rdy_c = 1'b1;
    endcase
    tick();
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    rdy_c = 1'b0;
  endtask

  task automatic release_fir();
    fov = 1'b1;
    tick();
    fov = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h34, 8'h12, 16'h1234};
    vecs[1] = '{8'hFF, 8'h00, 16'h00FF};
    vecs[2] = '{8'h00, 8'h80, 16'h8000};
    vecs[3] = '{8'hA5, 8'h5A, 16'h5AA5};
    cvecs[0] = '{8'h01, 8'h10, 2'd1};
    cvecs[1] = '{8'h02, 8'h20, 2'd2};
    cvecs[2] = '{8'h03, 8'h30, 2'd3};
    cvecs[3] = '{8'h04, 8'h40, 2'd0};
    cvecs[4] = '{8'h05, 8'h50, 2'd1};

    tick();
    tick();
    rst = 1'b0;
    check("rst_data_a", data_a, 0);
    check("rst_valid_a", val_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_idx_a", idx_a, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_ovr_a", ovr_a, 0);
    check("rst_ferr_a", ferr_a, 0);
    check("rst_data_b", data_b, 0);
    check("rst_cnt_c", cnt_c, 0);

    // LSB-first 2-word samples
    for (int i = 0; i < 4; i++) begin
      word(0, vecs[i].b0);
      check("idx_mid_a", idx_a, 1);
      check("no_early_valid_a", val_a, 0);
      word(0, vecs[i].b1);
      check("valid_a", val_a, 1);
      check("data_a", data_a, vecs[i].exp_data);
      check("busy_disp_a", busy_a, 1);
      check("idx_wrap_a", idx_a, 0);
      tick();
      check("valid_pulse_a", val_a, 0);
      check("busy_wait_a", busy_a, 1);
      check("cnt_a", cnt_a, i + 1);
      release_fir();
      check("busy_release_a", busy_a, 0);
    end

    // fir_out_valid ignored in DISPATCH, overrun in WAIT_OUT and on exit cycle
    word(0, 8'h0D);
    word(0, 8'hF0);
    check("valid_ovr_a", val_a, 1);
    fov = 1'b1;
    tick();
    fov = 1'b0;
    check("fov_ignored_disp", busy_a, 1);
    check("cnt5_a", cnt_a, 5);
    word(0, 8'h55);
    check("ovr_pulse_a", ovr_a, 1);
    check("ovr_data_hold_a", data_a, 16'hF00D);
    check("ovr_idx_a", idx_a, 0);
    tick();
    check("ovr_clear_a", ovr_a, 0);
    rx_data = 8'h66;
    rdy_a = 1'b1;
    fov = 1'b1;
    tick();
    rdy_a = 1'b0;
    fov = 1'b0;
    check("exit_busy_a", busy_a, 0);
    check("exit_ovr_a", ovr_a, 1);
    check("exit_idx_a", idx_a, 0);
    check("exit_data_a", data_a, 16'hF00D);
    word(0, 8'h78);
    word(0, 8'h56);
    check("post_ovr_valid_a", val_a, 1);
    check("post_ovr_data_a", data_a, 16'h5678);
    tick();
    check("post_ovr_cnt_a", cnt_a, 6);
    release_fir();

    // MSB-first 3-word sample
    word(1, 8'hAA);
    check("idx1_b", idx_b, 1);
    word(1, 8'hBB);
    check("idx2_b", idx_b, 2);
    word(1, 8'hCC);
    check("valid_b", val_b, 1);
    check("data_b", data_b, 24'hAABBCC);
    tick();
    check("cnt_b", cnt_b, 1);
    release_fir();

    // Timeout fires on the 8th idle cycle
    word(1, 8'h11);
    repeat (7) tick();
    check("no_ferr_early_b", ferr_b, 0);
    check("idx_hold_b", idx_b, 1);
    tick();
    check("ferr_b", ferr_b, 1);
    check("ferr_idx_b", idx_b, 0);
    check("ferr_data_b", data_b, 24'h11BBCC);
    tick();
    check("ferr_pulse_b", ferr_b, 0);

    // A word on the expiry cycle wins
    word(1, 8'h22);
    repeat (7) tick();
    word(1, 8'h33);
    check("rescue_ferr_b", ferr_b, 0);
    check("rescue_idx_b", idx_b, 2);
    tick();
    check("rescue_ferr2_b", ferr_b, 0);
    word(1, 8'h44);
    check("rescue_valid_b", val_b, 1);
    check("rescue_data_b", data_b, 24'h223344);
    tick();
    check("rescue_cnt_b", cnt_b, 2);
    release_fir();

    // Reset mid-sample and in WAIT_OUT
    word(0, 8'h99);
    check("pre_rst_idx_a", idx_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst1_idx_a", idx_a, 0);
    check("rst1_data_a", data_a, 0);
    check("rst1_cnt_a", cnt_a, 0);
    word(0, 8'h34);
    word(0, 8'h12);
    tick();
    check("pre_rst2_busy_a", busy_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_busy_a", busy_a, 0);
    check("rst2_valid_a", val_a, 0);
    check("rst2_cnt_a", cnt_a, 0);
    check("rst2_data_a", data_a, 0);
    word(0, 8'hCD);
    word(0, 8'hAB);
    check("rst_after_data_a", data_a, 16'hABCD);
    tick();
    check("rst_after_cnt_a", cnt_a, 1);
    release_fir();

    // Narrow sample counter wraps
    for (int i = 0; i < 5; i++) begin
      word(2, cvecs[i].b0);
      word(2, cvecs[i].b1);
      check("valid_c", val_c, 1);
      check("data_c", data_c, {cvecs[i].b1, cvecs[i].b0});
      tick();
      check("cnt_c", cnt_c, cvecs[i].exp_cnt);
      release_fir();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
